sync_fifo_ctrl: RTL
===================

// Module: sync_fifo_ctrl
// PURPOSE
//  Control side of the synchronous FIFO. It drives an external 2^L x W dual-port RAM:
//   - write port: data/address, active-low write strobe
//   - read port: registered read address, active-low read strobe; read data is valid 1 cycle after the strobe
//  The block owns the pointers, full/empty/count and the push/pop handshake toward the user logic.
// PARAMETERS
//  W  8  data width (bits)
//  L  5  RAM address width; DEPTH = 1<<L = 32 entries
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    asynchronous reset, active-high
//  push        in   1    write request
//  din         in   W    write data
//  full        out  1    FIFO holds DEPTH entries
//  pop         in   1    read request
//  dout        out  W    read data (= mem_data_b)
//  dout_vld    out  1    dout carries the word popped last cycle
//  empty       out  1    FIFO holds 0 entries
//  count       out  L+1  occupancy, 0..DEPTH
//  mem_wr_n    out  1    RAM write strobe, active-low
//  mem_addr_a  out  L    RAM write address
//  mem_data_a  out  W    RAM write data (= din)
//  mem_rd_n    out  1    RAM read strobe, active-low (RAM registers addr_b when low)
//  mem_addr_b  out  L    RAM read address
//  mem_data_b  in   W    RAM read data
// BEHAVIOUR
//  - Pointers: wptr and rptr are L+1 bits; the MSB is the wrap bit.
//    - RAM addresses are ptr[L-1:0]; each pointer increments mod 2^(L+1).
//  - push_acc = push & ~full & ~rst;  pop_acc = pop & ~empty & ~rst.
//  - mem_wr_n = ~push_acc and mem_rd_n = ~pop_acc, both combinational.
//    - mem_addr_a = wptr[L-1:0]; mem_addr_b = rptr[L-1:0].
//  - On each clk edge: push_acc -> wptr+1; pop_acc -> rptr+1.
//    - Both accepted in the same cycle: both pointers advance and count is unchanged.
//  - empty = (wptr == rptr).
//  - full  = (wptr[L] != rptr[L]) && (wptr[L-1:0] == rptr[L-1:0]).
//  - count = wptr - rptr (L+1 bits); empty, full and count are combinational decodes of registered pointers.
//  - Read latency is 1: dout_vld <= pop_acc (registered).
//    - dout = mem_data_b and holds the last-read word while no pop occurs.
//  - Push while full: dropped, no RAM write, pointers unchanged.
//  - Pop while empty: dropped, mem_rd_n stays 1, dout_vld = 0 next cycle.
//  - Push+pop while full: only the pop is accepted. Push+pop while empty: only the push is accepted.
//    - No bypass; the word pushed into an empty FIFO is poppable from the next cycle.
//  - No read/write address collision can occur:
//    - writes are blocked when full;
//    - reads are blocked when empty.
//  - Reset (asynchronous, any cycle, including mid-burst):
//    - wptr = rptr = 0, dout_vld = 0; hence empty = 1, full = 0, count = 0.
//    - mem_wr_n = mem_rd_n = 1 while rst = 1.
//    - RAM contents are not cleared; they are logically discarded.
// CONFIGURATION
//  Macro SYNC_FIFO_CTRL_ERR_EN.
//  - Defined: adds ports ovf (out, 1) and udf (out, 1).
//    - Sticky flags: set on a push while full / a pop while empty.
//    - Cleared only by rst; reset value 0.
//  - Undefined: the ports do not exist and dropped requests are silent. Core behaviour is identical.
// STRUCTURE
//  - Package fifo_pkg: DEPTH = 1<<L, PTR_W = L+1, and function f_count(wptr, rptr).
//  - Sub-module fifo_ptr:
//    - (L+1)-bit pointer register with async active-high clear and an increment enable;
//    - instantiated twice (write and read).
//  - The RAM is instantiated beside this block by the FIFO top, not inside it.
// TESTING
//  1. Assert rst, release it, idle -> empty=1, full=0, count=0, dout_vld=0, mem_wr_n=mem_rd_n=1.
//  2. Push 0x01..0x20 on 32 consecutive cycles -> count 32, full=1; a 33rd push gives mem_wr_n=1 and wptr unchanged.
//  3. From full, pop 32 times -> dout 0x01..0x20 in order, each 1 cycle after its pop, with dout_vld=1; then empty=1.
//  4. Count=5, push and pop together for 40 cycles -> count stays 5 and the pointers wrap; data order is preserved.
//  5. Pop while empty -> mem_rd_n=1, dout_vld=0; with SYNC_FIFO_CTRL_ERR_EN, udf=1 and it stays set.
//  6. Count=10, assert rst mid-burst -> empty=1, count=0 immediately; a push of 0xA5 followed by a pop returns 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO controller constants and the occupancy helper.
package fifo_pkg;
  localparam int W = 8;
  localparam int L = 5;
  localparam int DEPTH = 1 << L;
  localparam int PTR_W = L + 1;
  function automatic logic [PTR_W-1:0] f_count(input logic [PTR_W-1:0] wptr, input logic [PTR_W-1:0] rptr);
    return wptr - rptr;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with async clear and increment enable.
module fifo_ptr #(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_d, ptr_q;
  always_comb ptr_d = en ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer/flag/handshake control for a FIFO over an external dual-port RAM.
// Optional sticky ovf/udf error ports when SYNC_FIFO_CTRL_ERR_EN is defined.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int W = fifo_pkg::W,
  parameter int L = fifo_pkg::L
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         empty,
  output logic [L:0]   count,
  output logic         mem_wr_n,
  output logic [L-1:0] mem_addr_a,
  output logic [W-1:0] mem_data_a,
  output logic         mem_rd_n,
  output logic [L-1:0] mem_addr_b,
  input  logic [W-1:0] mem_data_b
`ifdef SYNC_FIFO_CTRL_ERR_EN
  ,
  output logic         ovf,
  output logic         udf
`endif
);
  logic [L:0] wptr, rptr;
  logic push_acc, pop_acc, dout_vld_d, dout_vld_q;
  always_comb begin
    push_acc = push & ~full & ~rst;
    pop_acc = pop & ~empty & ~rst;
    dout_vld_d = pop_acc;
  end
  fifo_ptr #(.PW(L + 1)) u_wptr (.clk(clk), .rst(rst), .en(push_acc), .ptr(wptr));
  fifo_ptr #(.PW(L + 1)) u_rptr (.clk(clk), .rst(rst), .en(pop_acc), .ptr(rptr));
  assign empty = wptr == rptr;
  assign full = (wptr[L] != rptr[L]) && (wptr[L-1:0] == rptr[L-1:0]);
  assign count = f_count(wptr, rptr);
  assign mem_wr_n = ~push_acc;
  assign mem_rd_n = ~pop_acc;
  assign mem_addr_a = wptr[L-1:0];
  assign mem_addr_b = rptr[L-1:0];
  assign mem_data_a = din;
  assign dout = mem_data_b;
  assign dout_vld = dout_vld_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) dout_vld_q <= 1'b0;
    else dout_vld_q <= dout_vld_d;
`ifdef SYNC_FIFO_CTRL_ERR_EN
  logic ovf_d, ovf_q, udf_d, udf_q;
  always_comb begin
    ovf_d = ovf_q | (push & full);
    udf_d = udf_q | (pop & empty);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign ovf = ovf_q;
  assign udf = udf_q;
`endif
endmodule
